// File: rtl/car_tick_scheduler.sv
// car_tick_scheduler: base-tick prescaler, per-car period counters, pending
// bitmap and a round-robin valid/ready offer FSM for the car datapath.
// Optional feature macro: CAR_SCHED_OVERRUN_CNT_EN builds the saturating
// overrun counter; without it o_Overrun_Count is tied to 0.
module car_tick_scheduler #(
  parameter int                     NUM_CARS      = 10,
  parameter int                     IDX_WIDTH     = 4,
  parameter int                     c_TICK_DIV    = 700000,
  parameter int                     TICK_WIDTH    = 21,
  parameter logic [NUM_CARS*4-1:0]  c_LANE_PERIOD = {10{4'd1}}
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Enable,
  input  logic [1:0]            i_Level,
  output logic                  o_Frame_Tick,
  output logic                  o_Upd_Valid,
  output logic [IDX_WIDTH-1:0]  o_Upd_Car,
  output logic                  o_Upd_Dir,
  input  logic                  i_Upd_Ready,
  output logic [NUM_CARS-1:0]   o_Pending,
  output logic [7:0]            o_Overrun_Count
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                 state, state_next;
  logic [TICK_WIDTH-1:0]  presc;
  logic                   tick_step;
  logic                   handshake;
  logic [NUM_CARS-1:0]    expire;
  logic [NUM_CARS-1:0]    clear_mask;
  logic [NUM_CARS-1:0]    pending_next;
  logic [IDX_WIDTH-1:0]   ptr, ptr_next;
  logic [IDX_WIDTH-1:0]   car_next, sel_idx, cand;
  logic                   valid_next, dir_next, sel_found;

  // Lane counters step on the same edge that the prescaler wraps.
  assign tick_step = i_Enable && (presc == TICK_WIDTH'(c_TICK_DIV - 1));
  assign handshake = (state == OFFER) && i_Upd_Ready;

  // Prescaler and one-cycle frame tick; both freeze while disabled.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      presc        <= '0;
      o_Frame_Tick <= 1'b0;
    end else begin
      o_Frame_Tick <= tick_step;
      if (i_Enable) presc <= tick_step ? '0 : presc + TICK_WIDTH'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_lane
    localparam logic [3:0] PER  = c_LANE_PERIOD[gi*4 +: 4];
    localparam logic [3:0] INIT = (PER == 4'd0) ? 4'd1 : PER;
    logic [3:0] cnt;
    logic [3:0] cnt_shift;
    logic [3:0] eff;

    // Speed level is sampled only when this lane reloads.
    assign cnt_shift      = INIT >> i_Level;
    assign eff            = (cnt_shift == 4'd0) ? 4'd1 : cnt_shift;
    assign expire[gi]     = tick_step && (cnt == 4'd1);
    assign clear_mask[gi] = handshake && (o_Upd_Car == IDX_WIDTH'(gi));

    // Per-lane period countdown in base ticks.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)       cnt <= INIT;
      else if (tick_step) cnt <= (cnt == 4'd1) ? eff : cnt - 4'd1;
    end
  end

  // A new expiry wins over a grant clearing the same bit.
  assign pending_next = (o_Pending & ~clear_mask) | expire;

  // Pending bitmap register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) o_Pending <= '0;
    else          o_Pending <= pending_next;
  end

`ifdef CAR_SCHED_OVERRUN_CNT_EN
  logic [NUM_CARS-1:0]  overrun_vec;
  logic [IDX_WIDTH:0]   ovr_hits;
  logic [8:0]           ovr_sum;

  assign overrun_vec = expire & o_Pending & ~clear_mask;

  // Number of lanes dropping an update this edge, added to the running count.
  always_comb begin
    ovr_hits = '0;
    for (int i = 0; i < NUM_CARS; i++)
      ovr_hits = ovr_hits + {{IDX_WIDTH{1'b0}}, overrun_vec[i]};
    ovr_sum = {1'b0, o_Overrun_Count} + 9'(ovr_hits);
  end

  // Saturating overrun counter.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) o_Overrun_Count <= 8'd0;
    else          o_Overrun_Count <= (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];
  end
`else
  assign o_Overrun_Count = 8'd0;
`endif

  // Round-robin pick: first pending car above the last grant, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CARS; i++) begin
      cand = IDX_WIDTH'((int'(ptr) + i) % NUM_CARS);
      if (!sel_found && o_Pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Offer FSM next state: latch a pick in IDLE, hold it in OFFER until ready.
  always_comb begin
    state_next = state;
    valid_next = o_Upd_Valid;
    car_next   = o_Upd_Car;
    dir_next   = o_Upd_Dir;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_next = OFFER;
          valid_next = 1'b1;
          car_next   = sel_idx;
          dir_next   = sel_idx[0];
        end
      end
      OFFER: begin
        if (i_Upd_Ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          ptr_next   = o_Upd_Car;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Offer FSM state and registered request outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      o_Upd_Valid <= 1'b0;
      o_Upd_Car   <= '0;
      o_Upd_Dir   <= 1'b0;
      ptr         <= IDX_WIDTH'(NUM_CARS - 1);
    end else begin
      state       <= state_next;
      o_Upd_Valid <= valid_next;
      o_Upd_Car   <= car_next;
      o_Upd_Dir   <= dir_next;
      ptr         <= ptr_next;
    end
  end

endmodule

// File: doc/car_tick_scheduler.md
# car_tick_scheduler

Time-base and update scheduler for the lane cars. It divides the system clock into a base game tick and runs one period counter per car. Each car's updates are queued as a pending bit. Pending updates go out one at a time, round-robin, over a valid/ready handshake to the car position datapath. That datapath only needs to step the granted car; it no longer owns its own slow-down counter or car sequencing.

## Interface
- `NUM_CARS`, 10: number of cars/lanes scheduled.
- `IDX_WIDTH`, 4: width of a car index; must satisfy 2^IDX_WIDTH >= NUM_CARS.
- `c_TICK_DIV`, 700000: clock cycles per base tick; must be >= 2.
- `TICK_WIDTH`, 21: prescaler width; must satisfy 2^TICK_WIDTH > c_TICK_DIV.
- `c_LANE_PERIOD`, {10{4'd1}}: packed 4-bit period per car, in base ticks; car k is at bits [k*4 +: 4]; a value of 0 is treated as 1.
- `i_Clk`, input, 1: system clock; everything updates on the rising edge.
- `i_Rst_L`, input, 1: reset, asynchronous, active-low.
- `i_Enable`, input, 1: when 0, freezes the prescaler and lane counters.
- `i_Level`, input, 2: speed level; effective period = max(1, period >> i_Level).
- `o_Frame_Tick`, output, 1: one-cycle pulse per base tick.
- `o_Upd_Valid`, output, 1: update request valid.
- `o_Upd_Car`, output, IDX_WIDTH: index of the car to step.
- `o_Upd_Dir`, output, 1: 0 = move right (even index), 1 = move left (odd index).
- `i_Upd_Ready`, input, 1: datapath accepts the request.
- `o_Pending`, output, NUM_CARS: pending-update bitmap.
- `o_Overrun_Count`, output, 8: saturating count of dropped updates.

## Operation
- Reset values: all outputs 0; prescaler 0; round-robin pointer NUM_CARS-1; each lane counter loaded with max(1, c_LANE_PERIOD[k]); FSM in IDLE.
- Prescaler:
  - Counts while i_Enable = 1.
  - At the edge where it equals c_TICK_DIV-1: wraps to 0, drives o_Frame_Tick high for the next cycle, and steps every lane counter on that same edge.
- Lane counter k, on each base tick:
  - If it equals 1: reload with the effective period computed from the current i_Level, and set pending[k].
  - Otherwise: decrement.
  - A change to i_Level takes effect only at that lane's next reload.
- Overrun: lane k expires while pending[k] is already 1 and pending[k] is not being cleared by a handshake on the same edge. The bit stays 1 and o_Overrun_Count increments. It saturates at 255.
- Simultaneous expiry and handshake on the same car: the set wins. pending[k] stays 1 and no overrun is counted.
- FSM has two states: IDLE and OFFER.
  - IDLE: if o_Pending != 0, select the first set bit searching upward from pointer+1 and wrapping. Register o_Upd_Car and o_Upd_Dir (= index bit 0), set o_Upd_Valid, and go to OFFER.
  - OFFER: hold o_Upd_Valid, o_Upd_Car and o_Upd_Dir stable until i_Upd_Ready = 1 at an edge. On that edge: clear the granted pending bit, set pointer to the granted car, drop o_Upd_Valid, and return to IDLE.
- i_Enable = 0: no ticks are generated and pending bits hold. An offer already in flight still completes, and pending updates still drain.
- Asynchronous reset at any time, including mid-offer: o_Upd_Valid drops without waiting for a clock, and all state returns to its reset values.

## Timing
- o_Frame_Tick and the resulting pending bits become visible in the same cycle.
- Latency from pending visible to o_Upd_Valid high: 1 cycle.
- Throughput: at most one grant every 2 cycles. A handshake in the first OFFER cycle gives back-to-back grants 2 cycles apart.
- The request is held indefinitely under backpressure; nothing is dropped inside the FSM.
- Design constraint: NUM_CARS*2 < c_TICK_DIV, so every lane can be drained within one tick when there is no backpressure.

## Configuration
- `CAR_SCHED_OVERRUN_CNT_EN`:
  - Defined: o_Overrun_Count operates as described.
  - Undefined: no counter logic is built and o_Overrun_Count is tied to 0. Overrun behaviour of the pending bits is unchanged.

## Test plan
Unless stated, parameters are c_TICK_DIV=32, NUM_CARS=10, all periods 1, i_Level=0, i_Upd_Ready=1.
- Reset and order: hold i_Rst_L=0 and check all outputs are 0. Release with i_Enable=1. Expect o_Frame_Tick high in cycle 32 after release, then grants to cars 0,1,…,9 every 2 cycles. o_Upd_Dir must alternate 0,1, and car 9 must have dir 1.
- Backpressure: i_Upd_Ready=0 for 10 cycles once car 0 is offered. Valid and o_Upd_Car=0 stay stable throughout; when ready rises, pending[0] clears and car 1 follows 2 cycles later.
- Period: c_LANE_PERIOD[2]=3, all others 0xF. pending[2] sets on ticks 3, 6 and 9 only.
- Level: c_LANE_PERIOD[0]=8, i_Level=2 applied after reset. The first expiry comes at tick 8; later expiries come every 2 ticks.
- Overrun: i_Upd_Ready=0 across 2 ticks after the first tick. o_Overrun_Count=20, or 0 with the macro undefined; o_Pending=0x3FF.
- Asynchronous reset mid-offer: pull i_Rst_L low between clock edges while o_Upd_Valid=1. Valid must be 0 before the next edge, and o_Pending must be 0.
